// File: rtl/pci_req_arbiter.sv
// pci_req_arbiter: round-robin sharing of one PCI master port among NUM_REQ bridges.
// Define PCI_ARB_TIMEOUT_EN to add a per-grant watchdog that reports expiry on s_err.
module pci_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [NUM_REQ-1:0]        s_req,
   input  logic [NUM_REQ-1:0]        s_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] s_addr,
   input  logic [NUM_REQ*DATA_W-1:0] s_wdata,
   output logic [NUM_REQ-1:0]        s_gnt,
   output logic [DATA_W-1:0]         s_rdata,
   output logic [NUM_REQ-1:0]        s_ready,
   output logic [NUM_REQ-1:0]        s_err,
   output logic                      m_req,
   output logic                      m_wr,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_wdata,
   input  logic [DATA_W-1:0]         m_rdata,
   input  logic                      m_ready
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0] last_q, last_d, win, idx;
   logic done, expire;
   assign done = m_ready || !s_req[last_q];
`ifdef PCI_ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wdog_q, wdog_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   always_comb begin
      wdog_d = (state_q == GRANT) ? wdog_q + WW'(1) : '0;
      expire = (state_q == GRANT) && !done && (wdog_q == WW'(TIMEOUT));
      err_d  = expire ? gnt_q : '0;
   end
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wdog_q <= '0;
         err_q  <= '0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end
   assign s_err = err_q;
`else
   assign expire = 1'b0;
   assign s_err  = '0;
`endif
   // scan downward so the nearest set bit after last_q is the one left standing
   always_comb begin
      win = last_q;
      idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = IW'((int'(last_q) + i) % NUM_REQ);
         if (s_req[idx]) win = idx;
      end
   end
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (|s_req) begin
            state_d = GRANT;
            gnt_d   = NUM_REQ'(1) << win;
            last_d  = win;
         end
         GRANT: if (done || expire) begin
            state_d = RELEASE;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end
   assign s_gnt   = gnt_q;
   assign m_req   = (state_q == GRANT);
   assign m_wr    = |(gnt_q & s_wr);
   assign m_addr  = m_req ? s_addr[int'(last_q)*ADDR_W +: ADDR_W] : '0;
   assign m_wdata = m_req ? s_wdata[int'(last_q)*DATA_W +: DATA_W] : '0;
   assign s_ready = m_ready ? gnt_q : '0;
   assign s_rdata = m_rdata;
endmodule

// File: tb/tb_pci_req_arbiter.sv
// tb_pci_req_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_pci_req_arbiter;
   localparam int N = 4, AW = 32, DW = 32, TO = 8;
   logic HCLK = 1'b0, HRESETn = 1'b0;
   logic [N-1:0] s_req = '0, s_wr = '0;
   logic [N*AW-1:0] s_addr = '0;
   logic [N*DW-1:0] s_wdata = '0;
   logic [N-1:0] s_gnt, s_ready, s_err;
   logic [DW-1:0] s_rdata, m_rdata = '0;
   logic m_req, m_wr, m_ready = 1'b0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int pass_cnt = 0, tot_cnt = 0, last_g = N - 1;

   pci_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_gnt(s_gnt), .s_rdata(s_rdata), .s_ready(s_ready), .s_err(s_err),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int i = 1; i <= N; i++) if (req[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return N'(1) << i;
   endfunction

   task automatic wait_gnt(input int max, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (s_gnt != '0) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      s_req = '1; m_ready = 1'b1;
      repeat (2) @(negedge HCLK);
      tot_cnt++; if (s_gnt !== '0) $display("FAIL reset_gnt: got %b want 0", s_gnt); else pass_cnt++;
      tot_cnt++; if (m_req !== 1'b0) $display("FAIL reset_mreq: got %b want 0", m_req); else pass_cnt++;
      tot_cnt++; if (s_ready !== '0) $display("FAIL reset_ready: got %b want 0", s_ready); else pass_cnt++;
      tot_cnt++; if ({m_wr, m_addr, m_wdata} !== '0) $display("FAIL reset_mbus: got %b/%h/%h want 0", m_wr, m_addr, m_wdata); else pass_cnt++;
      tot_cnt++; if (s_err !== '0) $display("FAIL reset_err: got %b want 0", s_err); else pass_cnt++;
      s_req = '0; m_ready = 1'b0;
      @(posedge HCLK); #1 HRESETn = 1'b1;
      tick();
      tot_cnt++; if (s_gnt !== '0) $display("FAIL reset_idle_gnt: got %b want 0", s_gnt); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int c, exp;
      s_req = '1;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(8, c);
         exp = rr_pick(s_req, last_g);
         last_g = exp;
         tot_cnt++; if (s_gnt !== onehot(exp)) $display("FAIL rr_order%0d: got %b want %b", k, s_gnt, onehot(exp)); else pass_cnt++;
         tot_cnt++; if (exp !== k % N) $display("FAIL rr_model%0d: got %0d want %0d", k, exp, k % N); else pass_cnt++;
         tot_cnt++; if (c !== (k == 0 ? 1 : 2)) $display("FAIL rr_latency%0d: got %0d want %0d", k, c, k == 0 ? 1 : 2); else pass_cnt++;
         tick(); tick();
         m_ready = 1'b1; #1;
         tot_cnt++; if ($countones(s_gnt) !== 1) $display("FAIL rr_onehot%0d: got %b want one bit", k, s_gnt); else pass_cnt++;
         tot_cnt++; if (s_ready !== onehot(exp)) $display("FAIL rr_ready%0d: got %b want %b", k, s_ready, onehot(exp)); else pass_cnt++;
         tick();
         m_ready = 1'b0;
         if (k == 4) s_req = '0;
         tot_cnt++; if (s_gnt !== '0 || m_req !== 1'b0) $display("FAIL rr_release%0d: got %b/%b want 0/0", k, s_gnt, m_req); else pass_cnt++;
      end
      tick();
   endtask

   task automatic test_single();
      s_req = 4'b0010; s_wr = 4'b0010;
      s_addr[AW +: AW] = 32'h1000; s_wdata[DW +: DW] = 32'hDEADBEEF;
      tick();
      last_g = 1;
      tot_cnt++; if (s_gnt !== 4'b0010 || m_req !== 1'b1) $display("FAIL single_gnt: got %b/%b want 0010/1", s_gnt, m_req); else pass_cnt++;
      tot_cnt++; if (m_addr !== 32'h1000 || m_wr !== 1'b1) $display("FAIL single_addr: got %h/%b want 1000/1", m_addr, m_wr); else pass_cnt++;
      tot_cnt++; if (m_wdata !== 32'hDEADBEEF) $display("FAIL single_wdata: got %h want deadbeef", m_wdata); else pass_cnt++;
      tick(); tick();
      tot_cnt++; if (s_ready !== '0) $display("FAIL single_early_ready: got %b want 0", s_ready); else pass_cnt++;
      tick();
      m_ready = 1'b1; #1;
      tot_cnt++; if (s_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", s_ready); else pass_cnt++;
      tick();
      m_ready = 1'b0; s_req = '0; s_wr = '0;
      tot_cnt++; if (s_gnt !== '0 || m_req !== 1'b0 || m_addr !== '0) $display("FAIL single_drop: got %b/%b/%h want 0/0/0", s_gnt, m_req, m_addr); else pass_cnt++;
      tick();
   endtask

   task automatic test_read();
      s_req = 4'b0100; s_wr = '0; s_addr[2*AW +: AW] = 32'h20;
      tick();
      last_g = 2;
      tot_cnt++; if (s_gnt !== 4'b0100 || m_wr !== 1'b0 || m_addr !== 32'h20) $display("FAIL read_gnt: got %b/%b/%h want 0100/0/20", s_gnt, m_wr, m_addr); else pass_cnt++;
      tick();
      m_rdata = 32'h12345678; m_ready = 1'b1; #1;
      tot_cnt++; if (s_rdata !== 32'h12345678) $display("FAIL read_rdata: got %h want 12345678", s_rdata); else pass_cnt++;
      tot_cnt++; if (s_ready !== 4'b0100) $display("FAIL read_ready: got %b want 0100", s_ready); else pass_cnt++;
      tick();
      m_ready = 1'b0; s_req = '0;
      tick();
   endtask

   task automatic test_abort();
      s_req = 4'b1000;
      tick();
      last_g = 3;
      tot_cnt++; if (s_gnt !== 4'b1000) $display("FAIL abort_gnt: got %b want 1000", s_gnt); else pass_cnt++;
      s_req[0] = 1'b1;
      tick();
      s_req[3] = 1'b0; #1;
      tot_cnt++; if (s_ready !== '0) $display("FAIL abort_ready: got %b want 0", s_ready); else pass_cnt++;
      tick();
      m_ready = 1'b1; #1;
      tot_cnt++; if (s_gnt !== '0 || m_req !== 1'b0) $display("FAIL abort_release: got %b/%b want 0/0", s_gnt, m_req); else pass_cnt++;
      tot_cnt++; if (s_ready !== '0) $display("FAIL abort_rel_ready: got %b want 0", s_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (s_gnt !== '0 || s_ready !== '0) $display("FAIL abort_idle: got %b/%b want 0/0", s_gnt, s_ready); else pass_cnt++;
      m_ready = 1'b0;
      tick();
      last_g = 0;
      tot_cnt++; if (s_gnt !== 4'b0001) $display("FAIL abort_next: got %b want 0001", s_gnt); else pass_cnt++;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0; s_req = '0;
      tick();
   endtask

   task automatic test_async_reset();
      s_req = 4'b0100;
      tick();
      tot_cnt++; if (s_gnt !== 4'b0100) $display("FAIL areset_pre: got %b want 0100", s_gnt); else pass_cnt++;
      m_ready = 1'b1;
      #2 HRESETn = 1'b0;
      #1;
      tot_cnt++; if (s_gnt !== '0 || m_req !== 1'b0) $display("FAIL areset_now: got %b/%b want 0/0", s_gnt, m_req); else pass_cnt++;
      tot_cnt++; if (s_ready !== '0 || s_err !== '0) $display("FAIL areset_outs: got %b/%b want 0/0", s_ready, s_err); else pass_cnt++;
      m_ready = 1'b0; s_req = '1;
      @(posedge HCLK); #1 HRESETn = 1'b1;
      last_g = N - 1;
      tick();
      last_g = 0;
      tot_cnt++; if (s_gnt !== 4'b0001) $display("FAIL areset_first: got %b want 0001", s_gnt); else pass_cnt++;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0; s_req = '0;
      tick();
   endtask

   task automatic test_random();
      int exp, hold;
      logic [N-1:0] pat;
      logic [DW-1:0] rd;
      for (int it = 0; it < 30; it++) begin
         pat = N'($urandom_range(1, (1 << N) - 1));
         s_wr = N'($urandom);
         for (int r = 0; r < N; r++) begin
            s_addr[r*AW +: AW] = $urandom;
            s_wdata[r*DW +: DW] = $urandom;
         end
         s_req = pat;
         exp = rr_pick(pat, last_g);
         tick();
         last_g = exp;
         tot_cnt++; if (s_gnt !== onehot(exp) || m_req !== 1'b1) $display("FAIL rnd_gnt%0d: got %b want %b", it, s_gnt, onehot(exp)); else pass_cnt++;
         tot_cnt++; if (m_addr !== s_addr[exp*AW +: AW] || m_wdata !== s_wdata[exp*DW +: DW] || m_wr !== s_wr[exp])
            $display("FAIL rnd_bus%0d: got %h/%h/%b want %h/%h/%b", it, m_addr, m_wdata, m_wr, s_addr[exp*AW +: AW], s_wdata[exp*DW +: DW], s_wr[exp]);
         else pass_cnt++;
         hold = $urandom_range(0, 3);
         repeat (hold) tick();
         if ($urandom_range(0, 4) == 0) begin
            s_req[exp] = 1'b0; #1;
            tot_cnt++; if (s_ready !== '0) $display("FAIL rnd_abort_ready%0d: got %b want 0", it, s_ready); else pass_cnt++;
         end else begin
            rd = $urandom;
            m_rdata = rd; m_ready = 1'b1; #1;
            tot_cnt++; if (s_ready !== onehot(exp) || s_rdata !== rd) $display("FAIL rnd_ready%0d: got %b/%h want %b/%h", it, s_ready, s_rdata, onehot(exp), rd); else pass_cnt++;
         end
         tick();
         m_ready = 1'b0; s_req = '0;
         tot_cnt++; if (s_gnt !== '0 || m_req !== 1'b0 || s_err !== '0) $display("FAIL rnd_release%0d: got %b/%b/%b want 0/0/0", it, s_gnt, m_req, s_err); else pass_cnt++;
         tick();
      end
   endtask

`ifdef PCI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int err_at, err_cnt;
      logic [N-1:0] gnt_at9;
      err_at = -1; err_cnt = 0; gnt_at9 = 'x;
      s_req = 4'b0010;
      tick();
      tot_cnt++; if (s_gnt !== 4'b0010) $display("FAIL to_gnt: got %b want 0010", s_gnt); else pass_cnt++;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (s_err != '0) begin
            err_cnt++;
            if (err_at < 0 && s_err === 4'b0010) err_at = k;
         end
         if (k == 9) gnt_at9 = s_gnt;
      end
      tot_cnt++; if (err_at !== 9) $display("FAIL to_when: got %0d want 9", err_at); else pass_cnt++;
      tot_cnt++; if (err_cnt !== 1) $display("FAIL to_count: got %0d want 1", err_cnt); else pass_cnt++;
      tot_cnt++; if (gnt_at9 !== '0) $display("FAIL to_release: got %b want 0", gnt_at9); else pass_cnt++;
      s_req = '0;
      repeat (3) tick();
   endtask
`else
   task automatic test_timeout();
      int err_cnt;
      int lost;
      err_cnt = 0; lost = 0;
      s_req = 4'b0010;
      tick();
      for (int k = 0; k < 70; k++) begin
         if (s_err != '0) err_cnt++;
         if (s_gnt !== 4'b0010) lost++;
         tick();
      end
      tot_cnt++; if (lost !== 0) $display("FAIL nto_hold: got %0d lost cycles want 0", lost); else pass_cnt++;
      tot_cnt++; if (err_cnt !== 0) $display("FAIL nto_err: got %0d want 0", err_cnt); else pass_cnt++;
      s_req = '0;
      repeat (3) tick();
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_read();
      test_abort();
      test_async_reset();
      test_random();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/pci_req_arbiter.md
Name: pci_req_arbiter

Overview:
- Shares one downstream PCI master port between NUM_REQ AHB-to-PCI bridge instances.
- Each bridge's PCI_REQ/PCI_WR/PCI_ADDR/PCI_WDATA enters the arbiter, which grants one bridge at a time round-robin.
- The arbiter forwards the granted bridge's transaction to the shared port and routes PCI_RDATA/PCI_READY back to that bridge only.
- One transaction per grant; the grant is released after completion so no requester can starve another.

Parameters:
- NUM_REQ, 4, number of requesting bridges (2..8).
- ADDR_W, 32, PCI address width.
- DATA_W, 32, PCI data width.
- TIMEOUT, 64, watchdog limit in HCLK cycles (used only with PCI_ARB_TIMEOUT_EN).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- s_req  in  NUM_REQ  per-requester PCI_REQ.
- s_wr  in  NUM_REQ  per-requester PCI_WR (1 = write).
- s_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- s_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- s_gnt  out  NUM_REQ  one-hot grant, driven to each bridge's PCI_GNT.
- s_rdata  out  DATA_W  read data, valid for the granted requester.
- s_ready  out  NUM_REQ  per-requester PCI_READY.
- s_err  out  NUM_REQ  per-requester timeout error pulse.
- m_req  out  1  shared-port request.
- m_wr  out  1  shared-port write strobe.
- m_addr  out  ADDR_W  shared-port address.
- m_wdata  out  DATA_W  shared-port write data.
- m_rdata  in  DATA_W  shared-port read data.
- m_ready  in  1  shared-port completion.

Behaviour:
- Reset (HRESETn low, async): state=IDLE, s_gnt=0, m_req=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), s_err=0, watchdog=0. s_ready=0 and m_wr/m_addr/m_wdata=0 while no grant is held.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any s_req bit is set, the winner is the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: s_gnt[w]=1 and m_req=1 (both registered), last_grant=w, state=GRANT.
  - Latency: s_req sampled high in cycle N gives grant and m_req in cycle N+1.
- GRANT:
  - m_wr, m_addr and m_wdata are combinationally muxed from requester w's live inputs; requester w must hold them stable.
  - s_rdata=m_rdata at all times; s_ready[w]=m_ready combinationally; other s_ready bits stay 0.
  - On m_ready=1: completion. Next cycle: s_gnt=0, m_req=0, state=RELEASE.
  - If s_req[w] drops before m_ready (abort): next cycle s_gnt=0, m_req=0, state=RELEASE, and no s_ready is issued.
- RELEASE: one dead cycle with nothing granted, then IDLE. The earliest new grant therefore appears 3 cycles after the completing m_ready cycle (M+1 RELEASE, M+2 IDLE sampling, M+3 grant).
- Simultaneous requests: strict round-robin. After w is served, w has lowest priority.
- A requester that raises s_req while another holds the grant waits. Its request is not lost, because it is re-sampled in IDLE.
- m_ready while in IDLE or RELEASE is ignored and produces no s_ready.
- Reset asserted mid-transaction clears grant and m_req immediately (async). No s_ready or s_err is produced.
- Invariant: s_gnt is zero or one-hot on every cycle; m_req=1 only in GRANT.

Optional Feature:
- Macro: PCI_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts HCLK cycles in GRANT and clears on entry to GRANT.
  - If it reaches TIMEOUT without m_ready, then next cycle: s_err[w] pulses for 1 cycle, s_gnt and m_req clear, state=RELEASE.
  - m_ready arriving in the same cycle the count reaches TIMEOUT counts as a completion, not an error.
- Not defined: no counter is built, s_err is tied to 0, and GRANT waits indefinitely.

Test Plan:
- Single requester: s_req[1]=1 with addr 0x1000, write, wdata 0xDEADBEEF; m_ready pulses 3 cycles after grant. Required: s_gnt=4'b0010 one cycle after request; m_addr=0x1000, m_wr=1, m_wdata=0xDEADBEEF; s_ready[1] pulses in the m_ready cycle; grant drops the next cycle.
- Round-robin: s_req=4'b1111 held, each grant completed after 2 cycles. Required: grant order 0,1,2,3,0; never two bits of s_gnt set.
- Read return: requester 2 reads addr 0x20, m_rdata=0x12345678 on m_ready. Required: s_rdata=0x12345678 with s_ready=4'b0100; s_ready[0,1,3]=0.
- Abort: requester 3 drops s_req mid-GRANT. Required: grant clears next cycle, no s_ready, RELEASE, then requester 0 granted if it is pending.
- Async reset: assert HRESETn low during GRANT. Required: s_gnt=0, m_req=0 immediately; after release, the first grant goes to requester 0.
- Timeout (PCI_ARB_TIMEOUT_EN, TIMEOUT=8): grant requester 1 and never assert m_ready. Required: s_err[1] pulses exactly once, 9 cycles after grant; grant released.
